alu_issue_queue: RTL

//  ALU reservation station and issue scheduler: buffers dispatched ALU ops (rs_data), tracks operand readiness
//  via CDB wakeup, selects oldest ready entry (ROB age) and issues at most one op/cycle to the ALU FU + PRF read.

---
 rtl/alu_issue_queue_pkg.sv | 44 ++++
 rtl/alu_issue_queue_age_select.sv | 33 +++
 rtl/alu_issue_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_issue_queue_pkg.sv
// Shared types and ROB-tag arithmetic for the ALU issue queue.
package alu_issue_queue_pkg;

  localparam int IQ_PREG_W = 7;
  localparam int IQ_ROB_SZ = 16;
  localparam int ROB_W     = 5;

  typedef struct packed {
    logic [IQ_PREG_W-1:0] pd;
    logic [IQ_PREG_W-1:0] ps1;
    logic [IQ_PREG_W-1:0] ps2;
    logic [ROB_W-1:0]     rob_index;
    logic [6:0]           Opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [31:0]          imm;
  } rs_data;

  typedef struct packed {
    logic   valid;
    logic   rdy1;
    logic   rdy2;
    rs_data data;
  } iq_entry_t;

  // Distance of tag past head on the circular ROB; smaller is older.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                               input logic [ROB_W-1:0] head,
                                               input int sz);
    int d;
    d = (int'(tag) - int'(head)) % sz;
    if (d < 0) d = d + sz;
    return ROB_W'(d);
  endfunction

  // True when t lies strictly after start_excl and before end_excl.
  function automatic logic rob_in_range(input logic [ROB_W-1:0] t,
                                        input logic [ROB_W-1:0] start_excl,
                                        input logic [ROB_W-1:0] end_excl,
                                        input int sz);
    return rob_age(t, start_excl + 5'd1, sz) < rob_age(end_excl, start_excl + 5'd1, sz);
  endfunction

endpackage

// File: rtl/alu_issue_queue_age_select.sv
// Oldest-ready picker: eligible mask plus per-entry ROB age -> one-hot grant and index.
module alu_issue_queue_age_select
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = 3
) (
  input  logic [DEPTH-1:0]            elig,
  input  logic [DEPTH-1:0][ROB_W-1:0] age,
  output logic [DEPTH-1:0]            grant,
  output logic [IW-1:0]               idx,
  output logic                        any
);

  logic [ROB_W-1:0] best;

  // Ages of valid entries are unique, so strict less-than never has to break a tie.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    best = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && (!any || age[i] < best)) begin
        any  = 1'b1;
        idx  = IW'(i);
        best = age[i];
      end
    end
    grant = '0;
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds dispatched ops, wakes operands off the CDB,
// issues the oldest ready op each cycle and squashes wrong-path entries.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PREG_W = IQ_PREG_W,
  parameter int ROB_SZ = IQ_ROB_SZ
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_valid,
  input  rs_data            disp_data,
  input  logic              disp_ps1_rdy,
  input  logic              disp_ps2_rdy,
  output logic              rs_ready,
  input  logic              cdb_valid,
  input  logic [PREG_W-1:0] cdb_tag,
  input  logic [ROB_W-1:0]  rob_head,
  input  logic              fu_ready,
  output logic              issued,
  output rs_data            issue_data,
  input  logic              mispredict,
  input  logic [ROB_W-1:0]  mispredict_tag,
  input  logic [ROB_W-1:0]  curr_rob_tag
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  iq_entry_t [DEPTH-1:0]            ent_q, ent_d;
  logic [CW-1:0]                    count_q, count_d;
  logic                             issued_q, issued_d;
  rs_data                           issue_data_q, issue_data_d;

  logic [DEPTH-1:0]                 elig, grant, flush_mask;
  logic [DEPTH-1:0][ROB_W-1:0]      age;
  logic [IW-1:0]                    gidx, free_idx;
  logic                             any_elig, disp_fire, issue_fire;

  // Physical register 0 is hardwired; it is always dispatched ready and never woken.
  function automatic logic cdb_hit(input logic v, input logic [PREG_W-1:0] tag,
                                   input logic [IQ_PREG_W-1:0] ps);
    return v && (ps != '0) && (ps == tag);
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i]       = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
      age[i]        = rob_age(ent_q[i].data.rob_index, rob_head, ROB_SZ);
      flush_mask[i] = ent_q[i].valid &
                      rob_in_range(ent_q[i].data.rob_index, mispredict_tag, curr_rob_tag, ROB_SZ);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!ent_q[i].valid) free_idx = IW'(i);
  end

  alu_issue_queue_age_select #(.DEPTH(DEPTH), .IW(IW)) u_sel (
    .elig  (elig),
    .age   (age),
    .grant (grant),
    .idx   (gidx),
    .any   (any_elig)
  );

  // Space is judged on the registered count only; an issue this cycle frees nothing yet.
  assign rs_ready   = (count_q != CW'(DEPTH));
  assign disp_fire  = disp_valid & rs_ready & ~mispredict;
  assign issue_fire = fu_ready & any_elig & ~mispredict;

  always_comb begin
    ent_d        = ent_q;
    issued_d     = issue_fire;
    issue_data_d = issue_fire ? ent_q[gidx].data : issue_data_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_hit(cdb_valid, cdb_tag, ent_q[i].data.ps1)) ent_d[i].rdy1 = 1'b1;
      if (cdb_hit(cdb_valid, cdb_tag, ent_q[i].data.ps2)) ent_d[i].rdy2 = 1'b1;
      if (mispredict && flush_mask[i]) ent_d[i].valid = 1'b0;
      if (issue_fire && grant[i])      ent_d[i].valid = 1'b0;
    end

    // Slot comes from the start-of-cycle free set, so it never collides with the issuing entry.
    if (disp_fire) begin
      ent_d[free_idx].valid = 1'b1;
      ent_d[free_idx].data  = disp_data;
      ent_d[free_idx].rdy1  = disp_ps1_rdy | cdb_hit(cdb_valid, cdb_tag, disp_data.ps1);
      ent_d[free_idx].rdy2  = disp_ps2_rdy | cdb_hit(cdb_valid, cdb_tag, disp_data.ps2);
    end

    count_d = '0;
    for (int i = 0; i < DEPTH; i++)
      count_d = count_d + CW'(ent_d[i].valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q        <= '0;
      count_q      <= '0;
      issued_q     <= 1'b0;
      issue_data_q <= '0;
    end else begin
      ent_q        <= ent_d;
      count_q      <= count_d;
      issued_q     <= issued_d;
      issue_data_q <= issue_data_d;
    end
  end

  assign issued     = issued_q;
  assign issue_data = issue_data_q;

endmodule
